// File: rtl/framing_pkg.sv
// framing_pkg: state type and default tail bytes shared by framer and deframer
package framing_pkg;
  localparam logic [7:0] TAIL_CR = 8'h0D;
  localparam logic [7:0] TAIL_LF = 8'h0A;
  typedef enum logic [2:0] {payload_s, tail_0_s, tail_1_s, hunt_s, hunt_cr_s} deframer_state_e;
endpackage

// File: rtl/unpacker.sv
// unpacker: holds one packed word and emits its elements LSB-first with a last tag
module unpacker #(
  parameter int unpacked_width_p = 1,
  parameter int packed_num_p = 8,
  parameter int packed_width_p = unpacked_width_p * packed_num_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [packed_width_p-1:0]   data_i,
  input  logic                        last_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [unpacked_width_p-1:0] unpacked_o,
  output logic                        last_o
);
  localparam int IW = packed_num_p > 1 ? $clog2(packed_num_p) : 1;
  logic [packed_width_p-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic valid_q, valid_d, last_q, last_d, at_end, fin, load;
  assign at_end = idx_q == IW'(packed_num_p - 1);
  assign fin = valid_q && ready_i && at_end;
  // refilling on the final element keeps back-to-back words bubble-free
  assign ready_o = !valid_q || fin;
  assign load = valid_i && ready_o;
  assign valid_o = valid_q;
  assign last_o = valid_q && last_q && at_end;
  assign unpacked_o = unpacked_width_p'(data_q >> (32'(idx_q) * unpacked_width_p));
  always_comb begin
    data_d = load ? data_i : data_q;
    last_d = load ? last_i : last_q;
    idx_d = load || fin ? '0 : valid_q && ready_i ? idx_q + 1'b1 : idx_q;
    valid_d = load ? 1'b1 : fin ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
      last_q <= 1'b0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/deframer.sv
// deframer: strips and checks the packet tail, resynchronises on it, and unpacks payload words
module deframer import framing_pkg::*; #(
  parameter int unpacked_width_p = 1,
  parameter int packed_num_p = 8,
  parameter int packed_width_p = unpacked_width_p * packed_num_p,
  parameter int packet_len_elems_p = 1024,
  parameter logic [7:0] tail_byte_0_p = TAIL_CR,
  parameter logic [7:0] tail_byte_1_p = TAIL_LF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [packed_width_p-1:0]   data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [unpacked_width_p-1:0] unpacked_o,
  output logic                        last_o,
  output logic                        err_o
);
  localparam int CW = packet_len_elems_p > 1 ? $clog2(packet_len_elems_p) : 1;
  deframer_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, up_ready, is_t0, is_t1, cnt_last, acc;
  assign is_t0 = data_i == packed_width_p'(tail_byte_0_p);
  assign is_t1 = data_i == packed_width_p'(tail_byte_1_p);
  assign cnt_last = cnt_q == CW'(packet_len_elems_p - 1);
  assign ready_o = state_q == payload_s ? up_ready : 1'b1;
  assign acc = valid_i && ready_o;
  assign err_o = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (acc)
      case (state_q)
        payload_s: begin
          cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
          state_d = cnt_last ? tail_0_s : payload_s;
        end
        tail_0_s: begin
          state_d = is_t0 ? tail_1_s : hunt_s;
          err_d = !is_t0;
        end
        tail_1_s: begin
          state_d = is_t1 ? payload_s : is_t0 ? hunt_cr_s : hunt_s;
          err_d = !is_t1;
        end
        hunt_s: state_d = is_t0 ? hunt_cr_s : hunt_s;
        hunt_cr_s: begin
          state_d = is_t1 ? payload_s : is_t0 ? hunt_cr_s : hunt_s;
          cnt_d = '0;
        end
        default: state_d = payload_s;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= payload_s;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  unpacker #(
    .unpacked_width_p(unpacked_width_p),
    .packed_num_p(packed_num_p),
    .packed_width_p(packed_width_p)
  ) u_unpacker (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(valid_i && state_q == payload_s),
    .ready_o(up_ready),
    .data_i(data_i),
    .last_i(cnt_last),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .unpacked_o(unpacked_o),
    .last_o(last_o)
  );
endmodule

// File: tb/tb_deframer.sv
// tb_deframer: directed and randomized checks of two deframer configurations
module tb_deframer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v0, r0, vo0, ri0, l0, e0, v1, r1, vo1, ri1, l1, e1;
  logic [7:0] d0, d1, u1;
  logic [1:0] u0;
  int checks = 0, fails = 0, errs0 = 0;
  bit rnd = 1'b0;
  int got[$], exp[$];
  logic hold = 1'b0;
  logic [2:0] hv = '0;

  deframer #(.unpacked_width_p(2), .packed_num_p(4), .packet_len_elems_p(2)) dut0 (
    .clk_i(clk), .reset_i(rst), .valid_i(v0), .ready_o(r0), .data_i(d0),
    .valid_o(vo0), .ready_i(ri0), .unpacked_o(u0), .last_o(l0), .err_o(e0));
  deframer #(.unpacked_width_p(8), .packed_num_p(1), .packet_len_elems_p(3)) dut1 (
    .clk_i(clk), .reset_i(rst), .valid_i(v1), .ready_o(r1), .data_i(d1),
    .valid_o(vo1), .ready_i(ri1), .unpacked_o(u1), .last_o(l1), .err_o(e1));

  task automatic check(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // element collector and hold-stability check for dut0
  always @(negedge clk) begin
    if (hold) begin
      checks++;
      assert ({vo0, l0, u0} === {1'b1, hv}) else begin
        fails++;
        $error("FAIL hold: observed %b%b%b expected 1%b", vo0, l0, u0, hv);
      end
    end
    hold = vo0 && !ri0 && !rst;
    hv = {l0, u0};
    if (vo0 && ri0 && !rst) got.push_back(int'({l0, u0}));
    if (e0) errs0++;
  end

  task automatic tick();
    @(posedge clk); #1;
    ri0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send0(input logic [7:0] b);
    bit acc = 1'b0;
    v0 = 1'b1; d0 = b;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = r0;
      tick();
    end
    v0 = 1'b0;
    check("accept", int'(acc), 1);
  endtask

  task automatic word(input logic [7:0] b, input bit last);
    for (int k = 0; k < 4; k++) exp.push_back(int'({last && k == 3, b[2*k +: 2]}));
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b);
    word(a, 1'b0); word(b, 1'b1);
    send0(a); send0(b); send0(8'h0D); send0(8'h0A);
  endtask

  task automatic drain_cmp(input string tag);
    for (int t = 0; t < 300 && got.size() < exp.size(); t++) tick();
    repeat (4) tick();
    check({tag, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
    got.delete(); exp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, b;
    rst = 1'b1; v0 = 1'b0; d0 = '0; ri0 = 1'b1; v1 = 1'b0; d1 = '0; ri1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", int'(vo0), 0);
    check("rst last", int'(l0), 0);
    check("rst err", int'(e0), 0);
    check("rst ready", int'(r0), 1);
    check("rst data", int'(u0), 0);
    check("rst valid1", int'(vo1), 0);
    check("rst ready1", int'(r1), 1);
    rst = 1'b0;
    word(8'hE4, 1'b0); word(8'h1B, 1'b1);
    send0(8'hE4);
    check("latency valid", int'(vo0), 1);
    check("latency elem0", int'(u0), 0);
    check("full ready", int'(r0), 0);
    send0(8'h1B); send0(8'h0D); send0(8'h0A);
    drain_cmp("basic");
    check("basic err", errs0, 0);
    rnd = 1'b1;
    pkt(8'hE4, 8'h1B);
    drain_cmp("random ready");
    for (int p = 0; p < 3; p++) pkt(8'($urandom), 8'($urandom));
    drain_cmp("random pkts");
    rnd = 1'b0;
    pkt(8'h0D, 8'h0A);
    pkt(8'($urandom), 8'($urandom));
    drain_cmp("tail data");
    check("tail data err", errs0, 0);
    a = 8'($urandom); b = 8'($urandom);
    word(a, 1'b0); word(b, 1'b1);
    send0(a); send0(b); send0(8'h0D); send0(8'h55);
    check("err pulse", int'(e0), 1);
    send0(8'h33);
    check("err one cycle", int'(e0), 0);
    send0(8'h0D); send0(8'h0D); send0(8'h0A);
    pkt(8'($urandom), 8'($urandom));
    drain_cmp("resync");
    check("resync err", errs0, 1);
    a = 8'($urandom);
    exp.push_back(int'(a[1:0])); exp.push_back(int'(a[3:2]));
    send0(a);
    tick(); tick();
    rst = 1'b1; ri0 = 1'b0;
    @(posedge clk); #1;
    check("reset valid", int'(vo0), 0);
    check("reset ready", int'(r0), 1);
    rst = 1'b0; ri0 = 1'b1;
    pkt(8'($urandom), 8'($urandom));
    drain_cmp("after reset");
    check("reset err", errs0, 1);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 5; k++) begin
        b = k == 3 ? 8'h0D : k == 4 ? 8'h0A : 8'($urandom);
        v1 = 1'b1; d1 = b;
        @(negedge clk);
        check("n1 ready", int'(r1), 1);
        @(posedge clk); #1;
        check("n1 valid", int'(vo1), int'(k < 3));
        if (k < 3) begin
          check("n1 data", int'(u1), int'(b));
          check("n1 last", int'(l1), int'(k == 2));
        end
        check("n1 err", int'(e1), 0);
      end
    v1 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
